// File: rtl/float_to_int_scheduler.sv
// Round-robin front end that shares one combinational float32->int8 converter between two requesters.
// Latency: response valid CVT_LAT+1 cycles after the request handshake; one request per CVT_LAT+2 cycles at best.
// Backpressure: requests are refused while busy; the response is held until rsp_ready, which stalls the whole block.
// Optional build macro FTI_SATURATE_EN: saturate the captured result on overflow/underflow.
module float_to_int_scheduler #(
  // Cycles the converter output needs to settle after cvt_float changes (1..15).
  parameter int CVT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_float0,
  input  logic [31:0] req_float1,
  output logic [1:0]  req_ready,
  output logic [31:0] cvt_float,
  input  logic [7:0]  cvt_int,
  input  logic        cvt_ovf,
  input  logic        cvt_unf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_int,
  output logic        rsp_ovf,
  output logic        rsp_unf,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Settle counter is 4 bits wide, which covers the full CVT_LAT range.
  localparam logic [3:0] CNT_INIT = 4'(CVT_LAT);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cvt_float_q, cvt_float_d;
  logic        rsp_id_q, rsp_id_d;
  logic [7:0]  rsp_int_q, rsp_int_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_unf_q, rsp_unf_d;

  logic        grant_vld;
  logic        grant_id;
  logic [7:0]  cap_int;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_vld = |req_valid;
    grant_id  = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ~last_q;
    end else begin
      grant_id = req_valid[1];
    end
  end

`ifdef FTI_SATURATE_EN
  // Clamp the converter result using the sign of the operand still held on cvt_float.
  always_comb begin
    cap_int = cvt_int;
    if (cvt_ovf) begin
      cap_int = cvt_float_q[31] ? 8'h80 : 8'h7F;
    end else if (cvt_unf) begin
      cap_int = 8'h00;
    end
  end
`else
  // Converter result passes through unmodified.
  always_comb begin
    cap_int = cvt_int;
  end
`endif

  // Next-state and handshake logic; every register holds unless a transition touches it.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    cvt_float_d = cvt_float_q;
    rsp_id_d    = rsp_id_q;
    rsp_int_d   = rsp_int_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_unf_d   = rsp_unf_q;
    req_ready   = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          // The granted requester is valid by construction, so ready implies a handshake.
          req_ready   = grant_id ? 2'b10 : 2'b01;
          cvt_float_d = grant_id ? req_float1 : req_float0;
          rsp_id_d    = grant_id;
          last_d      = grant_id;
          cnt_d       = CNT_INIT;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_int_d = cap_int;
          rsp_ovf_d = cvt_ovf;
          rsp_unf_d = cvt_unf;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= 4'd0;
      cvt_float_q <= 32'd0;
      rsp_id_q    <= 1'b0;
      rsp_int_q   <= 8'd0;
      rsp_ovf_q   <= 1'b0;
      rsp_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      cvt_float_q <= cvt_float_d;
      rsp_id_q    <= rsp_id_d;
      rsp_int_q   <= rsp_int_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_unf_q   <= rsp_unf_d;
    end
  end

  assign cvt_float = cvt_float_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_int   = rsp_int_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_unf   = rsp_unf_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_float_to_int_scheduler.sv
// Directed bench for float_to_int_scheduler: one instance at CVT_LAT=1, one at CVT_LAT=4.
// The shared converter is a small lookup of hand-converted operands.
module tb_float_to_int_scheduler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A (CVT_LAT = 1)
  logic [1:0]  a_req_valid = 2'b00;
  logic [31:0] a_req_float0 = 32'd0, a_req_float1 = 32'd0;
  logic [1:0]  a_req_ready;
  logic [31:0] a_cvt_float;
  logic [7:0]  a_cvt_int;
  logic        a_cvt_ovf, a_cvt_unf;
  logic        a_rsp_valid, a_rsp_id, a_rsp_ovf, a_rsp_unf, a_busy;
  logic        a_rsp_ready = 1'b0;
  logic [7:0]  a_rsp_int;

  // Instance B (CVT_LAT = 4)
  logic [1:0]  b_req_valid = 2'b00;
  logic [31:0] b_req_float0 = 32'd0, b_req_float1 = 32'd0;
  logic [1:0]  b_req_ready;
  logic [31:0] b_cvt_float;
  logic [7:0]  b_cvt_int;
  logic        b_cvt_ovf, b_cvt_unf;
  logic        b_rsp_valid, b_rsp_id, b_rsp_ovf, b_rsp_unf, b_busy;
  logic        b_rsp_ready = 1'b0;
  logic [7:0]  b_rsp_int;
  logic        b_glitch = 1'b0;

  float_to_int_scheduler #(.CVT_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_float0(a_req_float0), .req_float1(a_req_float1),
    .req_ready(a_req_ready), .cvt_float(a_cvt_float),
    .cvt_int(a_cvt_int), .cvt_ovf(a_cvt_ovf), .cvt_unf(a_cvt_unf),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id),
    .rsp_int(a_rsp_int), .rsp_ovf(a_rsp_ovf), .rsp_unf(a_rsp_unf), .busy(a_busy)
  );

  float_to_int_scheduler #(.CVT_LAT(4)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_float0(b_req_float0), .req_float1(b_req_float1),
    .req_ready(b_req_ready), .cvt_float(b_cvt_float),
    .cvt_int(b_cvt_int), .cvt_ovf(b_cvt_ovf), .cvt_unf(b_cvt_unf),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
    .rsp_int(b_rsp_int), .rsp_ovf(b_rsp_ovf), .rsp_unf(b_rsp_unf), .busy(b_busy)
  );

  // Hand-converted operands: {int8, ovf, unf}
  function automatic logic [9:0] cvt_model(input logic [31:0] f);
    case (f)
      32'h40A00000: cvt_model = {8'h05, 1'b0, 1'b0}; //  5.0
      32'hC0400000: cvt_model = {8'hFD, 1'b0, 1'b0}; // -3.0
      32'h43480000: cvt_model = {8'hC8, 1'b1, 1'b0}; //  200.0 wraps
      32'hC3480000: cvt_model = {8'h38, 1'b1, 1'b0}; // -200.0 wraps
      32'h3E800000: cvt_model = {8'h00, 1'b0, 1'b1}; //  0.25
      32'h3F800000: cvt_model = {8'h01, 1'b0, 1'b0}; //  1.0
      32'h40000000: cvt_model = {8'h02, 1'b0, 1'b0}; //  2.0
      default:      cvt_model = {8'h00, 1'b0, 1'b0};
    endcase
  endfunction

  always_comb {a_cvt_int, a_cvt_ovf, a_cvt_unf} = cvt_model(a_cvt_float);
  // While b_glitch is set the B converter shows a bogus unsettled value.
  always_comb {b_cvt_int, b_cvt_ovf, b_cvt_unf} = b_glitch ? {8'hAA, 1'b1, 1'b0} : cvt_model(b_cvt_float);

`ifdef FTI_SATURATE_EN
  localparam logic [7:0] EXP_OVF_POS = 8'h7F;
  localparam logic [7:0] EXP_OVF_NEG = 8'h80;
`else
  localparam logic [7:0] EXP_OVF_POS = 8'hC8;
  localparam logic [7:0] EXP_OVF_NEG = 8'h38;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".req_ready"}, 32'(a_req_ready), 32'd0);
    chk({tag, ".cvt_float"}, a_cvt_float, 32'd0);
    chk({tag, ".rsp_valid"}, 32'(a_rsp_valid), 32'd0);
    chk({tag, ".rsp_id"},    32'(a_rsp_id), 32'd0);
    chk({tag, ".rsp_int"},   32'(a_rsp_int), 32'd0);
    chk({tag, ".rsp_ovf"},   32'(a_rsp_ovf), 32'd0);
    chk({tag, ".rsp_unf"},   32'(a_rsp_unf), 32'd0);
    chk({tag, ".busy"},      32'(a_busy), 32'd0);
  endtask

  // One isolated request on instance A; caller is 1 time unit past an edge with A idle.
  task automatic run_a(input string tag, input logic id, input logic [31:0] f,
                       input logic [7:0] ei, input logic eo, input logic eu);
    int cyc;
    if (id) begin a_req_float1 = f; a_req_valid = 2'b10; end
    else    begin a_req_float0 = f; a_req_valid = 2'b01; end
    #1;
    chk({tag, ".grant"}, 32'(a_req_ready), id ? 32'd2 : 32'd1);
    tick;
    a_req_valid = 2'b00;
    chk({tag, ".busy"}, 32'(a_busy), 32'd1);
    chk({tag, ".cvt_float"}, a_cvt_float, f);
    cyc = 1;
    while (!a_rsp_valid && cyc < 40) begin tick; cyc++; end
    chk({tag, ".latency"}, 32'(cyc), 32'd2);
    chk({tag, ".rsp_id"},  32'(a_rsp_id), 32'(id));
    chk({tag, ".rsp_int"}, 32'(a_rsp_int), 32'(ei));
    chk({tag, ".rsp_ovf"}, 32'(a_rsp_ovf), 32'(eo));
    chk({tag, ".rsp_unf"}, 32'(a_rsp_unf), 32'(eu));
    a_rsp_ready = 1'b1;
    tick;
    a_rsp_ready = 1'b0;
    chk({tag, ".idle_valid"}, 32'(a_rsp_valid), 32'd0);
    chk({tag, ".idle_busy"},  32'(a_busy), 32'd0);
  endtask

  int g_id[8], g_cyc[8], r_id[8], r_int[8];
  int gn, rn, cyc;

  initial begin
    // Reset state
    repeat (3) tick;
    chk_reset_a("reset");
    chk("reset.b_busy", 32'(b_busy), 32'd0);
    reset_n = 1'b1;
    tick;

    // Single and assorted operands
    run_a("pos5",   1'b0, 32'h40A00000, 8'h05, 1'b0, 1'b0);
    run_a("neg3",   1'b1, 32'hC0400000, 8'hFD, 1'b0, 1'b0);
    run_a("ovfpos", 1'b0, 32'h43480000, EXP_OVF_POS, 1'b1, 1'b0);
    run_a("ovfneg", 1'b1, 32'hC3480000, EXP_OVF_NEG, 1'b1, 1'b0);
    run_a("unf",    1'b0, 32'h3E800000, 8'h00, 1'b0, 1'b1);

    // Both requesters valid continuously from reset
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    a_req_float0 = 32'h3F800000;
    a_req_float1 = 32'h40000000;
    a_req_valid  = 2'b11;
    a_rsp_ready  = 1'b1;
    #1;
    gn = 0; rn = 0;
    for (int c = 0; c < 12; c++) begin
      if (a_req_ready != 2'b00 && gn < 8) begin
        g_id[gn] = int'(a_req_ready[1]); g_cyc[gn] = c; gn++;
      end
      if (a_rsp_valid && rn < 8) begin
        r_id[rn] = int'(a_rsp_id); r_int[rn] = int'(a_rsp_int); rn++;
      end
      tick;
    end
    a_req_valid = 2'b00;
    a_rsp_ready = 1'b0;
    chk("tie.grants", 32'(gn), 32'd4);
    chk("tie.rsps",   32'(rn), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tie.g%0d.id", k),   32'(g_id[k]), 32'(k % 2));
      chk($sformatf("tie.g%0d.cyc", k),  32'(g_cyc[k]), 32'(3 * k));
      chk($sformatf("tie.r%0d.id", k),   32'(r_id[k]), 32'(k % 2));
      chk($sformatf("tie.r%0d.int", k),  32'(r_int[k]), (k % 2 == 1) ? 32'd2 : 32'd1);
    end
    tick;

    // Backpressure: hold the response for 10 cycles while both requesters wait
    a_req_float0 = 32'h3F800000;
    a_req_valid  = 2'b01;
    #1;
    tick;
    a_req_valid = 2'b11;
    cyc = 1;
    while (!a_rsp_valid && cyc < 40) begin tick; cyc++; end
    chk("bp.latency", 32'(cyc), 32'd2);
    for (int k = 0; k < 10; k++) begin
      chk("bp.rsp_valid", 32'(a_rsp_valid), 32'd1);
      chk("bp.rsp_id",    32'(a_rsp_id), 32'd0);
      chk("bp.rsp_int",   32'(a_rsp_int), 32'h01);
      chk("bp.req_ready", 32'(a_req_ready), 32'd0);
      chk("bp.busy",      32'(a_busy), 32'd1);
      tick;
    end
    a_rsp_ready = 1'b1;
    tick;
    a_rsp_ready = 1'b0;
    chk("bp.rel_valid", 32'(a_rsp_valid), 32'd0);
    chk("bp.rel_busy",  32'(a_busy), 32'd0);
    chk("bp.rel_grant", 32'(a_req_ready), 32'd2);
    // Both requesters withdraw before the edge: nothing is accepted
    a_req_valid = 2'b00;
    tick;
    chk("abandon.busy", 32'(a_busy), 32'd0);

    // Settle time on instance B; converter output is unsettled in cycles 1..3
    b_req_float0 = 32'h40A00000;
    b_req_valid  = 2'b01;
    #1;
    chk("lat4.grant", 32'(b_req_ready), 32'd1);
    tick;
    b_req_valid = 2'b00;
    b_glitch = 1'b1;
    cyc = 1;
    while (!b_rsp_valid && cyc < 40) begin
      tick; cyc++;
      if (cyc == 4) b_glitch = 1'b0;
    end
    b_glitch = 1'b0;
    chk("lat4.latency", 32'(cyc), 32'd5);
    chk("lat4.rsp_id",  32'(b_rsp_id), 32'd0);
    chk("lat4.rsp_int", 32'(b_rsp_int), 32'h05);
    chk("lat4.rsp_ovf", 32'(b_rsp_ovf), 32'd0);
    b_rsp_ready = 1'b1;
    tick;
    b_rsp_ready = 1'b0;
    chk("lat4.idle", 32'(b_busy), 32'd0);

    // Reset while waiting for the converter
    a_req_float1 = 32'hC0400000;
    a_req_valid  = 2'b10;
    #1;
    tick;
    a_req_valid = 2'b00;
    chk("rstw.busy_before", 32'(a_busy), 32'd1);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    chk_reset_a("rstw");
    for (int k = 0; k < 6; k++) begin
      chk("rstw.no_rsp", 32'(a_rsp_valid), 32'd0);
      tick;
    end

    // Reset while presenting a response
    a_req_float0 = 32'h43480000;
    a_req_valid  = 2'b01;
    #1;
    tick;
    a_req_valid = 2'b00;
    tick;
    chk("rstr.valid_before", 32'(a_rsp_valid), 32'd1);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    chk_reset_a("rstr");
    for (int k = 0; k < 6; k++) begin
      chk("rstr.no_rsp", 32'(a_rsp_valid), 32'd0);
      tick;
    end
    a_req_valid = 2'b11;
    #1;
    chk("rstr.tie_grant", 32'(a_req_ready), 32'd1);
    a_req_valid = 2'b00;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/float_to_int_scheduler.md
# float_to_int_scheduler

Round-robin scheduler that shares one combinational float-to-signed-int converter (float32 in, 8-bit two's-complement out, overflow/underflow flags) between two requesters. Each request is accepted with a valid/ready handshake, and its operand is registered into the converter. After a programmable settle time the result is captured, then returned with the requester ID on a held response channel. The block sits between the FPU front-end ports and the shared conversion datapath.

## Interface
- `CVT_LAT`, default 1: cycles the converter output settles before capture; legal range 1..15.
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `req_valid` input [1:0]: per-requester request valid.
- `req_float0` input [31:0]: requester 0 float32 operand.
- `req_float1` input [31:0]: requester 1 float32 operand.
- `req_ready` output [1:0]: per-requester accept; one-hot or zero.
- `cvt_float` output [31:0]: registered operand driven to the shared converter.
- `cvt_int` input [7:0]: converter integer result.
- `cvt_ovf` input 1: converter overflow flag.
- `cvt_unf` input 1: converter underflow flag.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumer ready.
- `rsp_id` output 1: requester the response belongs to.
- `rsp_int` output [7:0]: result.
- `rsp_ovf` output 1: overflow flag.
- `rsp_unf` output 1: underflow flag.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE, requesting:** `req_ready` is asserted combinationally to the granted requester only.
  - Handshake on `req_valid[i] & req_ready[i]` loads the operand into `cvt_float`, records `rsp_id = i`, sets `cnt = CVT_LAT`, and moves to WAIT.
- **IDLE, no request:** with no `req_valid`, both `req_ready` bits are 0 and the FSM stays in IDLE.
- **Arbitration:** round-robin with a `last` pointer.
  - Only one requester valid: that requester wins.
  - Both valid: the requester not equal to `last` wins.
  - `last` updates on each grant.
  - After reset `last = 1`, so requester 0 wins the first tie.
- **WAIT:** `cnt` decrements each cycle.
  - When `cnt == 1`, `cvt_int`, `cvt_ovf` and `cvt_unf` are captured into the response registers and the FSM moves to RESP.
- **RESP:** `rsp_valid = 1`, and all `rsp_*` outputs are held stable.
  - On `rsp_valid & rsp_ready` the FSM moves to IDLE.
  - New requests are never accepted in WAIT or RESP.
- **Operand stability:** `cvt_float` holds its value until the next accepted request.
- **Abandoned requests:** a requester dropping `req_valid` before it is granted is not an error and is not recorded.
- **Flags:** `rsp_ovf` and `rsp_unf` always mirror the captured converter flags. At most one of them is set, because the converter guarantees this.

## Timing
- **Reset values:** `req_ready = 0`, `cvt_float = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_int = 0`, `rsp_ovf = 0`, `rsp_unf = 0`, `busy = 0`, state IDLE, `last = 1`, `cnt = 0`.
- **Latency:** with the handshake in cycle 0:
  - `busy` rises in cycle 1.
  - Capture happens at the end of cycle `CVT_LAT`.
  - `rsp_valid` rises in cycle `CVT_LAT + 1`.
- **Throughput:** with `rsp_ready` held high, the maximum rate is one request per `CVT_LAT + 2` cycles. The response handshake cycle is followed by one IDLE cycle before the next grant is possible.
- **Response hold:** `rsp_valid` stays high for any number of cycles with `rsp_ready = 0`; the outputs do not change.
- **Reset mid-operation:** synchronous `reset_n = 0` in any state returns the block to the reset values on the next edge.
  - The in-flight request and its response are discarded and are never presented.
- **Request ordering:** a requester that keeps `req_valid` high while the other is being served wins the next arbitration if the other is also valid. There is no starvation.

## Configuration
- **Macro:** `FTI_SATURATE_EN`.
- **Defined:** the captured result is saturated. Flags are unchanged.
  - Overflow with positive operand (`cvt_float[31] = 0`): `rsp_int = 8'h7F`.
  - Overflow with negative operand: `rsp_int = 8'h80`.
  - Underflow: `rsp_int = 8'h00`.
  - Otherwise: `rsp_int = cvt_int`.
- **Undefined:** `rsp_int = cvt_int` unmodified in all cases.

## Test plan
1. **Single request, positive:** `CVT_LAT = 1`; req0 sends `32'h40A00000` (5.0) -> grant in cycle 0; `rsp_valid` in cycle 2 with `rsp_id = 0`, `rsp_int = 8'h05`, `rsp_ovf = 0`, `rsp_unf = 0`.
2. **Negative, overflow and underflow operands:**
   - req1 sends `32'hC0400000` (-3.0) -> `rsp_int = 8'hFD`.
   - `32'h43480000` (200.0) -> `rsp_ovf = 1`; `rsp_int = 8'h7F` with `FTI_SATURATE_EN`, `8'hC8` without.
   - `32'h3E800000` (0.25) -> `rsp_unf = 1`, `rsp_int = 8'h00`.
3. **Simultaneous requests:** both requesters valid continuously from reset -> grants alternate 0, 1, 0, 1; `rsp_id` sequence matches; each grant is `CVT_LAT + 2` cycles apart with `rsp_ready = 1`.
4. **Backpressure:** `rsp_ready = 0` for 10 cycles after `rsp_valid` rises -> `rsp_*` stable, `req_ready = 2'b00` throughout, `busy = 1`; release -> IDLE next cycle.
5. **Settle time:** `CVT_LAT = 4` -> `rsp_valid` rises exactly 5 cycles after the handshake; the converter model changing output before cycle 4 does not affect the captured value.
6. **Reset mid-operation:** assert `reset_n = 0` in WAIT and in RESP -> next cycle all outputs are at reset values, no response is ever presented, and the next tie goes to requester 0.
